encrypt_round_engine: RTL



---
 rtl/encrypt_round_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/encrypt_round_engine.sv
// Purpose : iterative AES forward cipher, one round (SubBytes/ShiftRows/MixColumns/AddRoundKey) per clock.
// Latency : start sampled at edge T0, state_out written at edge T(NR), done pulses the cycle after; NR+2 cycles per block.
// Backpres: no flow control; start is only sampled in IDLE, so requests while busy or done are dropped.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, state_in   encrypt request and plaintext (byte 0 in [127:120], column-major)
//   round_key         key for round round_idx, supplied combinationally by an external key store
//   round_idx         round key index being consumed this cycle (0..NR)
//   busy, done        rounds in progress / one-cycle completion pulse
//   state_out         ciphertext register, held until the final round of the next block
//   abort             optional, present when ENC_ABORT_EN is defined: cancel the block in flight
module encrypt_round_engine #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     state_in,
    input  logic [127:0]     round_key,
`ifdef ENC_ABORT_EN
    input  logic             abort,
`endif
    output logic [IDX_W-1:0] round_idx,
    output logic             busy,
    output logic             done,
    output logic [127:0]     state_out
);

    localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    // Byte k (k = 4*column + row) lives at bits [127-8k -: 8].
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
        end
        return r;
    endfunction

    // Row r of the output takes the byte r columns to the right (left rotate by r).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        {a0, a1, a2, a3} = col;
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3*a is xtime(a) ^ a
        return {x0 ^ (x1 ^ a1) ^ a2 ^ a3,
                a0 ^ x1 ^ (x2 ^ a2) ^ a3,
                a0 ^ a1 ^ x2 ^ (x3 ^ a3),
                (x0 ^ a0) ^ a1 ^ a2 ^ x3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    fsm_e             fsm_q, fsm_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [127:0]     st_q,  st_d;
    logic [127:0]     out_q, out_d;

    logic [127:0] sr_w;
    logic [127:0] mid_w;
    logic [127:0] fin_w;

    assign sr_w  = shift_rows(sub_bytes(st_q));
    assign mid_w = mix_columns(sr_w) ^ round_key;
    assign fin_w = sr_w ^ round_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            cnt_q <= '0;
            st_q  <= '0;
            out_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        out_d = out_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    st_d  = state_in ^ round_key;
                    cnt_d = IDX_W'(1);
                    fsm_d = S_ROUND;
                end
            end
            S_ROUND: begin
`ifdef ENC_ABORT_EN
                if (abort) begin
                    // Cancel beats the final-round write: state_out keeps the old block.
                    cnt_d = '0;
                    fsm_d = S_IDLE;
                end else
`endif
                if (cnt_q == NR_IDX) begin
                    st_d  = fin_w;
                    out_d = fin_w;
                    cnt_d = '0;
                    fsm_d = S_DONE;
                end else begin
                    st_d  = mid_w;
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Status outputs decode registered state only; start never reaches them combinationally.
    assign busy      = (fsm_q == S_ROUND);
    assign done      = (fsm_q == S_DONE);
    assign round_idx = (fsm_q == S_ROUND) ? cnt_q : '0;
    assign state_out = out_q;

endmodule
